kbd_scan_decoder: RTL and testbench

KBD_SCAN_DECODER -- requirements
Module: kbd_scan_decoder

---
 rtl/kbd_pkg.sv | 38 +++
 rtl/kbd_keymap.sv | 105 ++++++++++
 rtl/kbd_scan_decoder.sv | 154 +++++++++++++++
 tb/tb_kbd_scan_decoder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// PS/2 scan-set-2 constants, prefix FSM states and keymap entry type for the BK keyboard decoder.
// Pure declarations: no latency, no flow control.
package kbd_pkg;
    localparam logic [7:0] PS2_E0    = 8'hE0;
    localparam logic [7:0] PS2_F0    = 8'hF0;
    localparam logic [7:0] PS2_E1    = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_F12    = 8'h07;

    localparam logic [7:0] RPL_BAT   = 8'hAA;
    localparam logic [7:0] RPL_ACK   = 8'hFA;
    localparam logic [7:0] RPL_ECHO  = 8'hEE;
    localparam logic [7:0] RPL_RSND  = 8'hFE;
    localparam logic [7:0] RPL_ERR0  = 8'h00;
    localparam logic [7:0] RPL_ERR1  = 8'hFF;

    // Bytes following E1 in the Pause make sequence.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } kbd_state_t;

    typedef struct packed {
        logic       ar2;
        logic [6:0] code;
    } kbd_entry_t;

    function automatic logic is_reply(input logic [7:0] b);
        return (b == RPL_BAT) || (b == RPL_ACK) || (b == RPL_ECHO) ||
               (b == RPL_RSND) || (b == RPL_ERR0) || (b == RPL_ERR1);
    endfunction
endpackage

// File: rtl/kbd_keymap.sv
// Combinational scan-code to BK key-code table; all-zero entry means untranslatable.
// Zero latency, no flow control.
module kbd_keymap
    import kbd_pkg::*;
(
    input  logic       shift,
    input  logic       e0,
    input  logic [7:0] code,
    output kbd_entry_t entry
);
    function automatic kbd_entry_t pick(input logic s, input logic [6:0] lo, input logic [6:0] hi);
        kbd_entry_t r;
        r.ar2  = 1'b0;
        r.code = s ? hi : lo;
        return r;
    endfunction

    function automatic kbd_entry_t fkey(input logic [6:0] c);
        kbd_entry_t r;
        r.ar2  = 1'b1;
        r.code = c;
        return r;
    endfunction

    always_comb begin
        entry = '0;
        if (e0) begin
            case (code)
                8'h6B: entry = pick(1'b0, 7'h08, 7'h08);
                8'h74: entry = pick(1'b0, 7'h19, 7'h19);
                8'h75: entry = pick(1'b0, 7'h1A, 7'h1A);
                8'h72: entry = pick(1'b0, 7'h1B, 7'h1B);
                8'h5A: entry = pick(1'b0, 7'h0A, 7'h0A);
                8'h14: entry = pick(1'b0, 7'h0E, 7'h0E);
                8'h11: entry = pick(1'b0, 7'h0F, 7'h0F);
                default: entry = '0;
            endcase
        end else begin
            case (code)
                8'h1C: entry = pick(shift, 7'h61, 7'h41);
                8'h32: entry = pick(shift, 7'h62, 7'h42);
                8'h21: entry = pick(shift, 7'h63, 7'h43);
                8'h23: entry = pick(shift, 7'h64, 7'h44);
                8'h24: entry = pick(shift, 7'h65, 7'h45);
                8'h2B: entry = pick(shift, 7'h66, 7'h46);
                8'h34: entry = pick(shift, 7'h67, 7'h47);
                8'h33: entry = pick(shift, 7'h68, 7'h48);
                8'h43: entry = pick(shift, 7'h69, 7'h49);
                8'h3B: entry = pick(shift, 7'h6A, 7'h4A);
                8'h42: entry = pick(shift, 7'h6B, 7'h4B);
                8'h4B: entry = pick(shift, 7'h6C, 7'h4C);
                8'h3A: entry = pick(shift, 7'h6D, 7'h4D);
                8'h31: entry = pick(shift, 7'h6E, 7'h4E);
                8'h44: entry = pick(shift, 7'h6F, 7'h4F);
                8'h4D: entry = pick(shift, 7'h70, 7'h50);
                8'h15: entry = pick(shift, 7'h71, 7'h51);
                8'h2D: entry = pick(shift, 7'h72, 7'h52);
                8'h1B: entry = pick(shift, 7'h73, 7'h53);
                8'h2C: entry = pick(shift, 7'h74, 7'h54);
                8'h3C: entry = pick(shift, 7'h75, 7'h55);
                8'h2A: entry = pick(shift, 7'h76, 7'h56);
                8'h1D: entry = pick(shift, 7'h77, 7'h57);
                8'h22: entry = pick(shift, 7'h78, 7'h58);
                8'h35: entry = pick(shift, 7'h79, 7'h59);
                8'h1A: entry = pick(shift, 7'h7A, 7'h5A);
                8'h16: entry = pick(shift, 7'h31, 7'h21);
                8'h1E: entry = pick(shift, 7'h32, 7'h40);
                8'h26: entry = pick(shift, 7'h33, 7'h23);
                8'h25: entry = pick(shift, 7'h34, 7'h24);
                8'h2E: entry = pick(shift, 7'h35, 7'h25);
                8'h36: entry = pick(shift, 7'h36, 7'h5E);
                8'h3D: entry = pick(shift, 7'h37, 7'h26);
                8'h3E: entry = pick(shift, 7'h38, 7'h2A);
                8'h46: entry = pick(shift, 7'h39, 7'h28);
                8'h45: entry = pick(shift, 7'h30, 7'h29);
                8'h4E: entry = pick(shift, 7'h2D, 7'h5F);
                8'h55: entry = pick(shift, 7'h3D, 7'h2B);
                8'h54: entry = pick(shift, 7'h5B, 7'h7B);
                8'h5B: entry = pick(shift, 7'h5D, 7'h7D);
                8'h4C: entry = pick(shift, 7'h3B, 7'h3A);
                8'h52: entry = pick(shift, 7'h27, 7'h22);
                8'h41: entry = pick(shift, 7'h2C, 7'h3C);
                8'h49: entry = pick(shift, 7'h2E, 7'h3E);
                8'h4A: entry = pick(shift, 7'h2F, 7'h3F);
                8'h0E: entry = pick(shift, 7'h60, 7'h7E);
                8'h5D: entry = pick(shift, 7'h5C, 7'h7C);
                8'h29: entry = pick(1'b0, 7'h20, 7'h20);
                8'h0D: entry = pick(1'b0, 7'h09, 7'h09);
                8'h5A: entry = pick(1'b0, 7'h0A, 7'h0A);
                8'h76: entry = pick(1'b0, 7'h03, 7'h03);
                8'h66: entry = pick(1'b0, 7'h18, 7'h18);
                8'h05: entry = fkey(7'h01);
                8'h06: entry = fkey(7'h02);
                8'h04: entry = fkey(7'h03);
                8'h0C: entry = fkey(7'h04);
                8'h03: entry = fkey(7'h05);
                8'h0B: entry = fkey(7'h06);
                8'h83: entry = fkey(7'h07);
                8'h0A: entry = fkey(7'h08);
                8'h01: entry = fkey(7'h09);
                default: entry = '0;
            endcase
        end
    end
endmodule

// File: rtl/kbd_scan_decoder.sv
// PS/2 scan-set-2 decoder producing BK key codes with autorepeat into a FWFT queue.
// key_valid rises one cycle after a push; full queue drops new entries and pulses overflow.
module kbd_scan_decoder
    import kbd_pkg::*;
#(
    parameter int CLK_HZ          = 50000000,
    parameter int FIFO_DEPTH      = 8,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 50
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_valid,
    input  logic [7:0] ps2_byte,
    output logic       key_valid,
    output logic [6:0] key_code,
    output logic       key_ar2,
    input  logic       key_ready,
    output logic       key_down,
    output logic       stop_key,
    output logic       overflow
);
    localparam int TICK_CYC = CLK_HZ / 1000;
    localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int MAX_MS   = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int TW       = $clog2(MAX_MS + 1);
    localparam int AW       = $clog2(FIFO_DEPTH);

    kbd_state_t  state;
    logic [2:0]  skip;
    logic        shift_l, shift_r;
    logic [8:0]  held;
    logic        tmr_run;
    logic [TW-1:0] tmr_ms;
    logic [PW-1:0] pre_cnt;
    kbd_entry_t  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic ev, ev_e0, ev_brk, is_shift_key, is_f12, held_hit, held_rel;
    logic ev_push, rep_fire, tick, push_req, do_push, do_pop, full, shift;
    kbd_entry_t ev_map, rep_map, push_dat, head;

    assign shift = shift_l | shift_r;

    kbd_keymap u_ev_map  (.shift(shift), .e0(ev_e0),   .code(ps2_byte),  .entry(ev_map));
    kbd_keymap u_rep_map (.shift(shift), .e0(held[8]), .code(held[7:0]), .entry(rep_map));

    always_comb begin
        ev     = 1'b0;
        ev_e0  = (state == ST_EXT) || (state == ST_EXT_BRK);
        ev_brk = (state == ST_BRK) || (state == ST_EXT_BRK);
        if (ps2_valid) begin
            case (state)
                ST_IDLE: ev = (ps2_byte != PS2_E0) && (ps2_byte != PS2_F0) &&
                              (ps2_byte != PS2_E1) && !is_reply(ps2_byte);
                ST_EXT:  ev = (ps2_byte != PS2_F0);
                ST_BRK, ST_EXT_BRK: ev = 1'b1;
                default: ev = 1'b0;
            endcase
        end
    end

    assign is_shift_key = !ev_e0 && ((ps2_byte == SC_LSHIFT) || (ps2_byte == SC_RSHIFT));
    assign is_f12       = !ev_e0 && (ps2_byte == SC_F12);
    assign held_hit     = key_down && ({ev_e0, ps2_byte} == held);
    assign ev_push      = ev && !ev_brk && !is_shift_key && !is_f12 && (ev_map != '0) && !held_hit;
    assign held_rel     = ev && ev_brk && held_hit;
    assign tick         = (pre_cnt == PW'(TICK_CYC - 1));
    // Releasing the held key in the expiry cycle cancels that repeat.
    assign rep_fire     = tmr_run && tick && (tmr_ms == TW'(1)) && !held_rel;
    assign push_req     = ev_push || rep_fire;
    assign push_dat     = ev_push ? ev_map : rep_map;

    assign key_valid = (count != '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign do_pop    = key_valid && key_ready;
    assign do_push   = push_req && (!full || do_pop);
    assign head      = mem[rd_ptr];
    assign key_code  = key_valid ? head.code : '0;
    assign key_ar2   = key_valid ? head.ar2  : 1'b0;

    always_ff @(posedge clk_sys) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= ST_IDLE;
            skip     <= '0;
            shift_l  <= 1'b0;
            shift_r  <= 1'b0;
            held     <= '0;
            key_down <= 1'b0;
            tmr_run  <= 1'b0;
            tmr_ms   <= '0;
            pre_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            stop_key <= 1'b0;
            overflow <= 1'b0;
        end else begin
            stop_key <= ev && !ev_brk && is_f12;
            overflow <= push_req && full && !do_pop;

            if (ps2_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (ps2_byte == PS2_E0) state <= ST_EXT;
                        else if (ps2_byte == PS2_F0) state <= ST_BRK;
                        else if (ps2_byte == PS2_E1) begin
                            state <= ST_PAUSE;
                            skip  <= PAUSE_SKIP;
                        end
                    end
                    ST_EXT:  state <= (ps2_byte == PS2_F0) ? ST_EXT_BRK : ST_IDLE;
                    ST_PAUSE: begin
                        if (skip == 3'd1) state <= ST_IDLE;
                        skip <= skip - 3'd1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (ev && is_shift_key) begin
                if (ps2_byte == SC_LSHIFT) shift_l <= !ev_brk;
                else                       shift_r <= !ev_brk;
            end

            if (tmr_run) pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (ev_push) begin
                held     <= {ev_e0, ps2_byte};
                key_down <= 1'b1;
                tmr_run  <= 1'b1;
                tmr_ms   <= TW'(REPEAT_DELAY_MS);
                pre_cnt  <= '0;
            end else if (held_rel) begin
                key_down <= 1'b0;
                tmr_run  <= 1'b0;
            end else if (tmr_run && tick) begin
                tmr_ms <= (tmr_ms == TW'(1)) ? TW'(REPEAT_RATE_MS) : tmr_ms - 1'b1;
            end

            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench for kbd_scan_decoder with a 10 kHz clock parameter so autorepeat fits in a short run.
module tb_kbd_scan_decoder;
    import kbd_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_valid = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       key_ready = 1'b0;
    logic       key_valid, key_ar2, key_down, stop_key, overflow;
    logic [6:0] key_code;

    int tests = 0;
    int fails = 0;
    int ovf_cnt = 0;
    int stop_cnt = 0;

    kbd_scan_decoder #(
        .CLK_HZ(10000), .FIFO_DEPTH(8), .REPEAT_DELAY_MS(500), .REPEAT_RATE_MS(50)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_valid(ps2_valid), .ps2_byte(ps2_byte),
        .key_valid(key_valid), .key_code(key_code), .key_ar2(key_ar2), .key_ready(key_ready),
        .key_down(key_down), .stop_key(stop_key), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (overflow) ovf_cnt++;
        if (stop_key) stop_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send(input logic [7:0] b, input logic rdy = 1'b0);
        @(negedge clk_sys);
        ps2_valid = 1'b1;
        ps2_byte  = b;
        key_ready = rdy;
        @(negedge clk_sys);
        ps2_valid = 1'b0;
        key_ready = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [6:0] code, input logic ar2);
        check({tag, "_vld"}, 32'(key_valid), 32'd1);
        check({tag, "_code"}, 32'(key_code), 32'(code));
        check({tag, "_ar2"}, 32'(key_ar2), 32'(ar2));
        key_ready = 1'b1;
        @(negedge clk_sys);
        key_ready = 1'b0;
    endtask

    initial begin
        // Reset held with a concurrent E0 strobe: the prefix must not survive.
        ps2_valid = 1'b1;
        ps2_byte  = 8'hE0;
        idle(2);
        ps2_valid = 1'b0;
        reset     = 1'b0;
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_ar2", 32'(key_ar2), 32'd0);
        check("rst_key_down", 32'(key_down), 32'd0);
        check("rst_stop_key", 32'(stop_key), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_state", 32'(dut.state), 32'(ST_IDLE));

        // Plain make/break and a function key
        send(8'h1C);
        check("a_valid_next", 32'(key_valid), 32'd1);
        check("a_down", 32'(key_down), 32'd1);
        send(8'hF0); send(8'h1C);
        check("a_up", 32'(key_down), 32'd0);
        pop("a", 7'h61, 1'b0);
        check("a_empty", 32'(key_valid), 32'd0);
        send(8'h05); send(8'hF0); send(8'h05);
        pop("f1", 7'h01, 1'b1);
        check("f1_empty", 32'(key_valid), 32'd0);

        // Shifted letter, shift not queued, shift released afterwards
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
        pop("sh_a", 7'h41, 1'b0);
        check("sh_empty", 32'(key_valid), 32'd0);
        send(8'h1C); send(8'hF0); send(8'h1C);
        pop("unsh_a", 7'h61, 1'b0);

        // Reply bytes ignored; F12 pulses stop_key only
        send(8'hFA); send(8'hAA);
        check("reply_empty", 32'(key_valid), 32'd0);
        send(8'h07); send(8'hF0); send(8'h07);
        idle(2);
        check("f12_stop", 32'(stop_cnt), 32'd1);
        check("f12_empty", 32'(key_valid), 32'd0);
        check("f12_down", 32'(key_down), 32'd0);

        // Autorepeat: make at t0, repeats at 500/550/600 ms, released ~640 ms
        send(8'hE0); send(8'h75);
        idle(6350);
        check("rep_down", 32'(key_down), 32'd1);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("rep_released", 32'(key_down), 32'd0);
        idle(1000);
        for (int i = 0; i < 4; i++) pop($sformatf("rep%0d", i), 7'h1A, 1'b0);
        check("rep_empty", 32'(key_valid), 32'd0);

        // Queue fill: 9 makes into depth 8, then push+pop while full
        send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
        send(8'h2B); send(8'h34); send(8'h33); send(8'h43);
        idle(2);
        check("ovf_once", 32'(ovf_cnt), 32'd1);
        send(8'h44, 1'b1);
        idle(2);
        check("ovf_full_pushpop", 32'(ovf_cnt), 32'd1);
        pop("q1", 7'h62, 1'b0); pop("q2", 7'h63, 1'b0); pop("q3", 7'h64, 1'b0);
        pop("q4", 7'h65, 1'b0); pop("q5", 7'h66, 1'b0); pop("q6", 7'h67, 1'b0);
        pop("q7", 7'h68, 1'b0); pop("q8", 7'h6F, 1'b0);
        check("q_empty", 32'(key_valid), 32'd0);
        send(8'hF0); send(8'h44);
        check("q_up", 32'(key_down), 32'd0);

        // Pause sequence swallowed, then space
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_idle", 32'(dut.state), 32'(ST_IDLE));
        check("pause_empty", 32'(key_valid), 32'd0);
        send(8'h29);
        pop("space", 7'h20, 1'b0);
        check("space_empty", 32'(key_valid), 32'd0);
        send(8'hF0); send(8'h29);

        // Reset discards a pending E0 prefix
        send(8'hE0);
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        send(8'h14);
        idle(1);
        check("rst_pfx_empty", 32'(key_valid), 32'd0);
        send(8'hE0); send(8'h14);
        pop("rus", 7'h0E, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h14);
        send(8'hE0); send(8'h11);
        pop("lat", 7'h0F, 1'b0);
        check("final_empty", 32'(key_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
